// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg
// Shared definitions for the PLL lock sequencer:
//   - seq_state_e   : sequencer state encoding
//   - cnt_width()   : width of the shared cycle counter
//   - DEF_*         : default timing constants for a 27 MHz reference
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } seq_state_e;

  // 27 MHz reference: 1 us PLL reset, 10 ms lock timeout, 100 us stability.
  localparam int unsigned DEF_PLL_RST_CYCLES      = 32'd27;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 32'd270000;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 32'd2700;
  localparam int unsigned DEF_STAGE_GAP_CYCLES    = 32'd16;
  localparam int unsigned DEF_N_STAGES            = 32'd2;

  // Counter wide enough to hold the largest terminal value of any state.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c,
                                            input int unsigned d);
    int unsigned m;
    m = a;
    m = (b > m) ? b : m;
    m = (c > m) ? c : m;
    m = (d > m) ? d : m;
    return $clog2(m + 32'd1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Generic two-flop synchronizer for a single asynchronous status bit.
// Ports:
//   clk_i   : destination clock
//   reset_i : synchronous active-high reset, clears both stages to 0
//   d_i     : asynchronous input bit
//   q_o     : synchronized output, two clk_i cycles after d_i
module sync_2ff (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture; meta_q may go metastable and gets a full cycle to settle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
// Drives the PLL reset from the free-running reference clock, waits for a
// continuously stable lock, then releases per-domain resets in order. Lock
// loss or lock timeout re-runs the whole sequence.
// Ports:
//   clk          : free-running reference clock (same net as PLL clkin)
//   reset        : synchronous active-high reset
//   pll_lock     : PLL lock, asynchronous to clk
//   pll_reset    : PLL reset, active-high
//   sys_reset    : per-stage active-high resets, bit 0 released first
//   ready        : high only while running
//   relock_count : lock losses after stability was reached, saturating
//   timeout_err  : sticky lock-timeout flag, cleared only by reset
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned STAGE_GAP_CYCLES    = DEF_STAGE_GAP_CYCLES,
  parameter int unsigned N_STAGES            = DEF_N_STAGES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pll_lock,
  output logic                pll_reset,
  output logic [N_STAGES-1:0] sys_reset,
  output logic                ready,
  output logic [7:0]          relock_count,
  output logic                timeout_err
);

  localparam int unsigned CW = cnt_width(LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES,
                                         PLL_RST_CYCLES, N_STAGES * STAGE_GAP_CYCLES);

  localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 32'd1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 32'd1);
  // The WAIT_LOCK cycle that first sees lock already counts as one stable
  // cycle, so STABLE itself only needs LOCK_STABLE_CYCLES-1 of them.
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 32'd2);
  localparam logic [CW-1:0] RELEASE_LAST = CW'((N_STAGES - 32'd1) * STAGE_GAP_CYCLES);

  seq_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pll_reset_q, pll_reset_d;
  logic [N_STAGES-1:0]  sys_reset_q, sys_reset_d;
  logic                 ready_q, ready_d;
  logic [7:0]           relock_q, relock_d;
  logic                 terr_q, terr_d;
  logic                 lock_s;

  sync_2ff u_lock_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (pll_lock),
    .q_o     (lock_s)
  );

  // Next state, shared counter, and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    relock_d    = relock_q;
    terr_d      = terr_q;
    pll_reset_d = 1'b0;
    ready_d     = 1'b0;
    sys_reset_d = {N_STAGES{1'b1}};

    case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = PLL_RST;
          cnt_d   = '0;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STABLE: begin
        // A glitch here is not a lock loss: just restart the wait and timeout.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_d  = PLL_RST;
          cnt_d    = '0;
          relock_d = (relock_q == 8'hFF) ? 8'hFF : relock_q + 8'd1;
        end else if (cnt_q == RELEASE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d  = PLL_RST;
          cnt_d    = '0;
          relock_d = (relock_q == 8'hFF) ? 8'hFF : relock_q + 8'd1;
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
      end
    endcase

    // Outputs follow the state being entered so they register in step with it.
    case (state_d)
      PLL_RST: begin
        pll_reset_d = 1'b1;
      end
      RELEASE: begin
        for (int k = 0; k < int'(N_STAGES); k++) begin
          sys_reset_d[k] = ~(cnt_d >= CW'(k * STAGE_GAP_CYCLES));
        end
      end
      RUN: begin
        sys_reset_d = {N_STAGES{1'b0}};
        ready_d     = 1'b1;
      end
      default: begin
        pll_reset_d = 1'b0;
      end
    endcase
  end

  // State, counter and output registers; reset overrides every other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      pll_reset_q <= 1'b1;
      sys_reset_q <= {N_STAGES{1'b1}};
      ready_q     <= 1'b0;
      relock_q    <= 8'd0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_reset_q <= pll_reset_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
      relock_q    <= relock_d;
      terr_q      <= terr_d;
    end
  end

  assign pll_reset    = pll_reset_q;
  assign sys_reset    = sys_reset_q;
  assign ready        = ready_q;
  assign relock_count = relock_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer
// Directed scenarios plus randomized lock activity. A timestamp-based
// reference model pushes the expected outputs of every clock edge into a
// queue; an independent monitor pops and compares on the falling edge.
module tb_pll_lock_sequencer;

  localparam int P = 4;
  localparam int T = 32;
  localparam int S = 8;
  localparam int G = 3;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pll_lock = 1'b0;
  logic         pll_reset;
  logic [N-1:0] sys_reset;
  logic         ready;
  logic [7:0]   relock_count;
  logic         timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [12:0] exp_q[$];

  pll_lock_sequencer #(
    .PLL_RST_CYCLES      (P),
    .LOCK_TIMEOUT_CYCLES (T),
    .LOCK_STABLE_CYCLES  (S),
    .STAGE_GAP_CYCLES    (G),
    .N_STAGES            (N)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pll_lock     (pll_lock),
    .pll_reset    (pll_reset),
    .sys_reset    (sys_reset),
    .ready        (ready),
    .relock_count (relock_count),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (timestamps, not states) -------------
  int   m_n = 0;          // edge number
  bit   m_started = 0;
  int   m_seq;            // edge at which the current PLL reset pulse began
  int   m_wait;           // edge from which the lock timeout is measured
  int   m_lock;           // edge at which the current lock run was first seen, -1 if none
  int   m_relock;
  bit   m_terr;
  bit   m_ls;
  bit   m_sync[$];        // two-cycle delay of the lock pin
  int   m_r;
  logic [1:0] m_sr;
  bit   m_rd;
  bit   m_pr;

  initial begin
    forever begin
      @(posedge clk);
      m_n++;
      if (reset === 1'b1) begin
        m_started = 1'b1;
        m_seq = m_n; m_wait = m_n + P; m_lock = -1;
        m_relock = 0; m_terr = 1'b0;
        m_sync = '{1'b0, 1'b0};
      end else if (m_started) begin
        m_ls = m_sync.pop_front();
        m_sync.push_back(pll_lock);
        if (m_n > m_seq + P) begin
          if (m_lock < 0) begin
            if (m_ls) m_lock = m_n;
            else if (m_n - m_wait == T) begin
              m_terr = 1'b1;
              m_seq = m_n; m_wait = m_n + P;
            end
          end else if (m_n - m_lock < S) begin
            if (!m_ls) begin m_lock = -1; m_wait = m_n; end
          end else if (!m_ls) begin
            m_relock = (m_relock < 255) ? m_relock + 1 : 255;
            m_seq = m_n; m_wait = m_n + P; m_lock = -1;
          end
        end
      end
      if (m_started) begin
        m_pr = (m_n - m_seq < P);
        m_sr = 2'b11; m_rd = 1'b0;
        if (m_lock >= 0 && m_n - m_lock >= S - 1) begin
          m_r = m_n - m_lock - (S - 1);
          for (int k = 0; k < N; k++) m_sr[k] = (m_r < k * G);
          m_rd = (m_r >= (N - 1) * G + 1);
        end
        exp_q.push_back({m_pr, m_sr, m_rd, m_relock[7:0], m_terr});
      end
    end
  end

  // ---------------- monitor ----------------------------------------------
  logic [12:0] mon_e, mon_a;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        mon_a = {pll_reset, sys_reset, ready, relock_count, timeout_err};
        n_checks++;
        if (mon_a !== mon_e) begin
          n_fail++;
          $display("FAIL cycle_outputs @%0t: got pll_reset=%b sys_reset=%b ready=%b relock_count=%0d timeout_err=%b, expected pll_reset=%b sys_reset=%b ready=%b relock_count=%0d timeout_err=%b",
                   $time, mon_a[12], mon_a[11:10], mon_a[9], mon_a[8:1], mon_a[0],
                   mon_e[12], mon_e[11:10], mon_e[9], mon_e[8:1], mon_e[0]);
        end
      end
    end
  end

  // ---------------- helpers ----------------------------------------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  function automatic bit cond(input int which);
    if (which == 0) return (ready === 1'b1);
    else return (sys_reset[0] === 1'b0);
  endfunction

  task automatic wait_cond(input int which, input int max_cyc, input string name, output int cyc);
    cyc = 0;
    while (!cond(which) && cyc < max_cyc) begin
      tick(1);
      cyc++;
    end
    if (!cond(which)) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: condition not reached within %0d cycles", name, max_cyc);
    end
  endtask

  // ---------------- stimulus ---------------------------------------------
  int cnt, cyc, t0, t1, t2, first, second;
  logic prev;
  int r_len;

  initial begin
    reset = 1'b1; pll_lock = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", int'({pll_reset, sys_reset, ready, relock_count, timeout_err}),
          int'({1'b1, 2'b11, 1'b0, 8'd0, 1'b0}));
    reset = 1'b0;

    // 1: normal bring-up
    cnt = pll_reset ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (pll_reset) cnt++;
    end
    check("s1_pll_reset_width", cnt, 4);
    pll_lock = 1'b1;
    t0 = -1; t1 = -1; t2 = -1;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (t0 < 0 && sys_reset[0] === 1'b0) t0 = k;
      if (t1 < 0 && sys_reset[1] === 1'b0) t1 = k;
      if (t2 < 0 && ready === 1'b1) t2 = k;
    end
    check("s1_sys_reset0_fall", t0, 10);
    check("s1_sys_reset1_fall", t1, 13);
    check("s1_ready_rise", t2, 14);

    // 2: one-cycle glitch five cycles into the stability window
    pll_lock = 1'b0;
    pulse_reset();
    tick(12);
    pll_lock = 1'b1;
    tick(5);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    wait_cond(0, 60, "s2_ready_wait", cyc);
    check("s2_ready_latency", 6 + cyc, 20);
    check("s2_relock_count", relock_count, 0);

    // 3: lock timeout, re-pulse period and sticky error
    pll_lock = 1'b0;
    pulse_reset();
    first = -1; second = -1; prev = pll_reset;
    for (int k = 1; k <= 110; k++) begin
      tick(1);
      if (pll_reset && !prev) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
      prev = pll_reset;
    end
    check("s3_first_repulse", first, 36);
    check("s3_repulse_period", second - first, 36);
    check("s3_timeout_err_set", timeout_err, 1);
    pll_lock = 1'b1;
    wait_cond(0, 80, "s3_ready_wait", cyc);
    check("s3_timeout_err_sticky", timeout_err, 1);

    // 6: reset while releasing with timeout_err set
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(3);
    wait_cond(1, 60, "s6_release_wait", cyc);
    check("s6_in_release", sys_reset, 2);
    reset = 1'b1;
    tick(1);
    check("s6_reset_values", int'({pll_reset, sys_reset, ready, relock_count, timeout_err}),
          int'({1'b1, 2'b11, 1'b0, 8'd0, 1'b0}));
    reset = 1'b0;

    // 4: lock loss in RUN, then saturation of relock_count
    wait_cond(0, 60, "s4_ready_wait", cyc);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(2);
    check("s4_loss_outputs", int'({pll_reset, sys_reset, ready, relock_count}),
          int'({1'b1, 2'b11, 1'b0, 8'd1}));
    for (int i = 0; i < 299; i++) begin
      wait_cond(0, 60, "s4_rerun_ready_wait", cyc);
      pll_lock = 1'b0;
      tick(1);
      pll_lock = 1'b1;
      tick(2);
    end
    check("s4_relock_saturated", relock_count, 255);

    // 5: lock loss between the two stage releases
    pulse_reset();
    wait_cond(1, 60, "s5_release_wait", cyc);
    pll_lock = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (sys_reset[1] === 1'b0) cnt++;
    end
    check("s5_sys_reset1_never_falls", cnt, 0);
    check("s5_sys_reset0_reasserted", sys_reset[0], 1);
    check("s5_relock_count", relock_count, 1);

    // randomized lock activity with occasional resets
    pulse_reset();
    for (int i = 0; i < 150; i++) begin
      r_len = $urandom_range(1, 40);
      if ($urandom_range(0, 19) == 0) pulse_reset();
      pll_lock = ($urandom_range(0, 3) != 0);
      tick(r_len);
    end

    tick(2);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
